band_mixer: RTL and testbench
=============================

Name: band_mixer

Overview:
- Downstream of the three biquad band filters (low/mid/high).
- Applies a per-band signed gain to each filtered output and sums the three results.
- Rounds and saturates the sum to one 16-bit audio sample for the output/DAC path.
- One time-multiplexed multiplier, valid/ready handshake on input and output; throughput far above audio sample rate.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- GAIN_W, 16, gain width (signed, Q2.14; 16384 = 1.0).
- GAIN_FRAC, 14, fractional bits of gain; also the final right-shift amount.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  band samples and gains valid
- in_ready  out  1  block can accept a new sample set
- in_low, in_mid, in_high  in  DATA_W each  filtered band samples
- g_low, g_mid, g_high  in  GAIN_W each  band gains, Q2.14
- out_valid  out  1  out_sample valid
- out_ready  in  1  consumer accepts out_sample
- out_sample  out  DATA_W  mixed, rounded, saturated sample
- out_clip  out  1  out_sample was saturated

Behaviour:
- Reset (reset low, async): state=IDLE; in_ready=1; out_valid=0; out_sample=0; out_clip=0; acc=0; idx=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch all 3 samples and 3 gains, acc<=0, idx<=0, go MAC.
  - MAC (3 cycles): acc <= acc + sample[idx]*gain[idx], idx 0->1->2 (low, mid, high). After idx=2, go SAT.
  - SAT: out_sample, out_clip, out_valid<=1 are registered; go HOLD.
  - HOLD: out_valid=1. When out_ready=1, out_valid<=0 and go IDLE.
- in_ready=1 only in IDLE.
- Gains and samples are latched at accept; input changes afterwards have no effect on the current sample.
- Latency: accept at edge k; out_valid high after edge k+4. Minimum 6 cycles per sample (HOLD 1 cycle + IDLE 1 cycle).
- Arithmetic widths:
  - Each product: 32-bit signed.
  - acc: 35-bit signed (3 products + rounding, no overflow).
- Round/saturate:
  - r = (acc + 2^13) >>> 14 (arithmetic shift, round half up).
  - If r > 32767: out_sample=32767, out_clip=1.
  - If r < -32768: out_sample=-32768, out_clip=1.
  - Otherwise out_sample=r[15:0], out_clip=0.
- out_sample and out_clip stay stable while out_valid=1 and out_ready=0 (unlimited backpressure).
- out_valid and out_ready high in the same cycle: transfer completes that edge. in_ready rises the next cycle; no same-cycle pass-through.
- in_valid while not in IDLE: ignored; the source must hold it until in_ready=1.
- Reset asserted in any state: immediate return to reset values; a partial sum is discarded and no output is produced.

Optional Feature:
- Macro: MIXER_CLIP_COUNT_EN.
- Defined:
  - Extra output port clip_count (16-bit).
  - Increments in SAT when out_clip is set; saturates at 65535 with no wrap; reset to 0.
  - Clears to 0 on a 1-cycle input clip_clear (also added).
  - If clip_clear and an increment occur in the same cycle, the clear wins.
- Not defined: no clip_count or clip_clear ports, no counter logic; all other behaviour identical.

Decomposition:
- Package mixer_pkg holds:
  - sample_t (signed 16) and gain_t (signed 16).
  - acc_t (signed 35).
  - GAIN_FRAC=14, SAT_MAX=32767, SAT_MIN=-32768.
  - State enum mixer_state_t {IDLE, MAC, SAT, HOLD}.
- One sub-module, mix_round_sat: combinational, acc_t in -> sample_t out + clip flag. Unit-testable on its own.

Test Plan:
- Unity gains (16384 ×3), samples 1000/2000/3000 -> out_sample=6000, out_clip=0, out_valid 4 cycles after accept.
- Gains 16384, samples 30000 ×3 -> out_sample=32767, out_clip=1. Samples -30000 ×3 -> -32768, out_clip=1. With MIXER_CLIP_COUNT_EN, clip_count=2.
- Rounding, g_low=8192 (0.5), others 0:
  - in_low=1 -> out_sample=1.
  - in_low=-1 -> out_sample=0.
  - in_low=3 -> out_sample=2.
- g_mid=0, g_low=g_high=16384, samples 1000/5000/3000 -> 4000. Then change gains one cycle after accept -> result still 4000.
- Backpressure:
  - Hold out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0 throughout, out_sample stable.
  - Raise out_ready -> next set accepted 1 cycle after the transfer.
- Drive reset low during MAC (idx=1) -> out_valid=0, in_ready=1 immediately. Next transaction 100/100/100 at unity -> 300.

Source files
------------

// File: rtl/mixer_pkg.sv
// Shared types and constants for the band mixer: sample/gain/accumulator
// types, rounding shift, saturation limits and FSM states.
package mixer_pkg;

  localparam int GAIN_FRAC = 14;

  typedef logic signed [15:0] sample_t;
  typedef logic signed [15:0] gain_t;
  typedef logic signed [34:0] acc_t;

  localparam sample_t SAT_MAX = 16'sh7FFF;
  localparam sample_t SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {IDLE, MAC, SAT, HOLD} mixer_state_t;

endpackage

// File: rtl/mix_round_sat.sv
// Combinational round-half-up and saturation of the mixer accumulator
// down to one output sample, with a clip flag.
module mix_round_sat
  import mixer_pkg::*;
#(
  parameter int FRAC = GAIN_FRAC
) (
  input  acc_t    i_acc,
  output sample_t o_sample,
  output logic    o_clip
);

  acc_t w_rnd;
  acc_t w_r;

  // Adding half an LSB before the arithmetic shift gives round-half-up.
  assign w_rnd = i_acc + (acc_t'(1) <<< (FRAC - 1));
  assign w_r   = w_rnd >>> FRAC;

  always_comb begin
    o_sample = w_r[15:0];
    o_clip   = 1'b0;
    if (w_r > acc_t'(SAT_MAX)) begin
      o_sample = SAT_MAX;
      o_clip   = 1'b1;
    end else if (w_r < acc_t'(SAT_MIN)) begin
      o_sample = SAT_MIN;
      o_clip   = 1'b1;
    end
  end

endmodule

// File: rtl/band_mixer.sv
// Three-band gain mixer with one shared multiplier and valid/ready handshake.
// Optional clip counter enabled by defining MIXER_CLIP_COUNT_EN.
//
// state | meaning
// IDLE  | ready for a new sample set
// MAC   | one band product accumulated per cycle (low, mid, high)
// SAT   | round/saturate accumulator into output registers
// HOLD  | output valid, waiting for consumer
module band_mixer
  import mixer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_low,
  input  logic [DATA_W-1:0] in_mid,
  input  logic [DATA_W-1:0] in_high,
  input  logic [GAIN_W-1:0] g_low,
  input  logic [GAIN_W-1:0] g_mid,
  input  logic [GAIN_W-1:0] g_high,
`ifdef MIXER_CLIP_COUNT_EN
  input  logic              clip_clear,
  output logic [15:0]       clip_count,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sample,
  output logic              out_clip
);

  mixer_state_t r_state;
  logic [1:0]   r_idx;
  acc_t         r_acc;
  sample_t      r_smp_low, r_smp_mid, r_smp_high;
  gain_t        r_g_low, r_g_mid, r_g_high;
  logic         r_in_ready, r_out_valid, r_out_clip;
  sample_t      r_out_sample;

  sample_t            w_smp;
  gain_t              w_gain;
  logic signed [31:0] w_prod;
  sample_t            w_sat_sample;
  logic               w_sat_clip;

  always_comb begin
    w_smp  = r_smp_low;
    w_gain = r_g_low;
    case (r_idx)
      2'd1:    begin w_smp = r_smp_mid;  w_gain = r_g_mid;  end
      2'd2:    begin w_smp = r_smp_high; w_gain = r_g_high; end
      default: begin w_smp = r_smp_low;  w_gain = r_g_low;  end
    endcase
  end

  assign w_prod = 32'(w_smp) * 32'(w_gain);

  mix_round_sat #(.FRAC(GAIN_FRAC)) u_round_sat (
    .i_acc    (r_acc),
    .o_sample (w_sat_sample),
    .o_clip   (w_sat_clip)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_idx        <= 2'd0;
      r_acc        <= '0;
      r_smp_low    <= '0;
      r_smp_mid    <= '0;
      r_smp_high   <= '0;
      r_g_low      <= '0;
      r_g_mid      <= '0;
      r_g_high     <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
      r_out_clip   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_smp_low  <= in_low;
            r_smp_mid  <= in_mid;
            r_smp_high <= in_high;
            r_g_low    <= g_low;
            r_g_mid    <= g_mid;
            r_g_high   <= g_high;
            r_acc      <= '0;
            r_idx      <= 2'd0;
            r_in_ready <= 1'b0;
            r_state    <= MAC;
          end
        end
        MAC: begin
          r_acc <= r_acc + acc_t'(w_prod);
          if (r_idx == 2'd2) begin
            r_state <= SAT;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        SAT: begin
          r_out_sample <= w_sat_sample;
          r_out_clip   <= w_sat_clip;
          r_out_valid  <= 1'b1;
          r_state      <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MIXER_CLIP_COUNT_EN
  logic [15:0] r_clip_count;

  // Clear takes priority over a same-cycle increment; count sticks at max.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clip_count <= '0;
    end else if (clip_clear) begin
      r_clip_count <= '0;
    end else if (r_state == SAT && w_sat_clip && r_clip_count != 16'hFFFF) begin
      r_clip_count <= r_clip_count + 16'd1;
    end
  end

  assign clip_count = r_clip_count;
`endif

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;
  assign out_clip   = r_out_clip;

endmodule

// File: tb/tb_band_mixer.sv
// Self-checking bench for band_mixer: directed cases plus randomized sets
// checked against an integer-arithmetic reference of the mixing rule.
module tb_band_mixer;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_low, in_mid, in_high;
  logic signed [15:0] g_low, g_mid, g_high;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_sample;
  logic               out_clip;
`ifdef MIXER_CLIP_COUNT_EN
  logic               clip_clear;
  logic [15:0]        clip_count;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;

  band_mixer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_low     (in_low),
    .in_mid     (in_mid),
    .in_high    (in_high),
    .g_low      (g_low),
    .g_mid      (g_mid),
    .g_high     (g_high),
`ifdef MIXER_CLIP_COUNT_EN
    .clip_clear (clip_clear),
    .clip_count (clip_count),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_clip   (out_clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: exact sum of products, round half up, clamp to 16 bits.
  task automatic model(input int l, m, h, gl, gm, gh,
                       output int exp_s, output int exp_c);
    longint sum;
    longint r;
    sum = longint'(l) * gl + longint'(m) * gm + longint'(h) * gh;
    r = (sum + 64'sd8192) >>> 14;
    exp_c = 0;
    if (r > 32767) begin
      exp_s = 32767; exp_c = 1;
    end else if (r < -32768) begin
      exp_s = -32768; exp_c = 1;
    end else begin
      exp_s = int'(r);
    end
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic scramble_inputs();
    in_low  = 16'(rnd16()); in_mid = 16'(rnd16()); in_high = 16'(rnd16());
    g_low   = 16'(rnd16()); g_mid  = 16'(rnd16()); g_high  = 16'(rnd16());
  endtask

  // Presents a set, waits for acceptance, then scrambles the input bus.
  task automatic accept(input int l, m, h, gl, gm, gh, input string tag);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk({tag, "_ready_timeout"}, 0, 1);
    in_low = 16'(l); in_mid = 16'(m); in_high = 16'(h);
    g_low  = 16'(gl); g_mid = 16'(gm); g_high = 16'(gh);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  // Counts edges from accept until out_valid; expects exactly 4.
  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, n, 4);
  endtask

  task automatic run_txn(input int l, m, h, gl, gm, gh, input int stall,
                         input string tag);
    int es, ec;
    model(l, m, h, gl, gm, gh, es, ec);
    accept(l, m, h, gl, gm, gh, tag);
    wait_out(tag);
    chk({tag, "_sample"}, out_sample, es);
    chk({tag, "_clip"}, out_clip, ec);
    repeat (stall) begin @(posedge clk); #1; end
    if (stall > 0) begin
      chk({tag, "_stall_sample"}, out_sample, es);
      chk({tag, "_stall_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_ready"}, in_ready, 1);
  endtask

  initial begin
    int es, ec;
    logic signed [15:0] held;
    logic all_ok;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef MIXER_CLIP_COUNT_EN
    clip_clear = 1'b0;
`endif
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_out_clip", out_clip, 0);
`ifdef MIXER_CLIP_COUNT_EN
    chk("rst_clip_count", clip_count, 0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    run_txn(1000, 2000, 3000, 16384, 16384, 16384, 0, "unity");
    run_txn(30000, 30000, 30000, 16384, 16384, 16384, 0, "clip_pos");
    run_txn(-30000, -30000, -30000, 16384, 16384, 16384, 0, "clip_neg");
`ifdef MIXER_CLIP_COUNT_EN
    chk("clip_count_2", clip_count, 2);
    clip_clear = 1'b1; @(posedge clk); #1; clip_clear = 1'b0;
    chk("clip_count_clr", clip_count, 0);
`endif
    run_txn(1, 0, 0, 8192, 0, 0, 0, "round_p1");
    run_txn(-1, 0, 0, 8192, 0, 0, 0, "round_m1");
    run_txn(3, 0, 0, 8192, 0, 0, 0, "round_p3");
    run_txn(1000, 5000, 3000, 16384, 0, 16384, 2, "latch");

    // Backpressure: next set waits on the bus while output is stalled.
    model(700, -200, 50, 16384, 8192, -16384, es, ec);
    accept(700, -200, 50, 16384, 8192, -16384, "bp1");
    wait_out("bp1");
    chk("bp1_sample", out_sample, es);
    held = out_sample;
    in_low = 16'sd111; in_mid = 16'sd222; in_high = 16'sd333;
    g_low = 16'sd16384; g_mid = 16'sd16384; g_high = 16'sd16384;
    in_valid = 1'b1;
    all_ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || out_sample !== held || out_valid !== 1'b1) all_ok = 1'b0;
    end
    chk("bp_stall_stable", all_ok, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_xfer_ready", in_ready, 1);
    chk("bp_xfer_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp2_accepted", in_ready, 0);
    wait_out("bp2");
    chk("bp2_sample", out_sample, 666);
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;

    // Reset in the middle of accumulation discards the partial sum.
    accept(5000, 5000, 5000, 16384, 16384, 16384, "rst_mac");
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_mac_valid", out_valid, 0);
    chk("rst_mac_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mac_no_out", out_valid, 0);
    run_txn(100, 100, 100, 16384, 16384, 16384, 0, "post_rst");

    for (int i = 0; i < 25; i++) begin
      int l, m, h, gl, gm, gh;
      l = rnd16(); m = rnd16(); h = rnd16();
      if (i % 3 == 0) begin
        gl = int'($urandom_range(0, 32768)) - 16384;
        gm = int'($urandom_range(0, 32768)) - 16384;
        gh = int'($urandom_range(0, 32768)) - 16384;
      end else begin
        gl = rnd16(); gm = rnd16(); gh = rnd16();
      end
      run_txn(l, m, h, gl, gm, gh, int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
